// File: rtl/wb_sel_pipe.sv
// Write-back select stage: decodes the destination register, selects write data from
// one of NSRC sources and registers the result with stall, flush and commit counting.
module wb_sel_pipe #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NSRC = 4,
  parameter int unsigned LINK = 31,
  parameter int unsigned CW   = 32,
  localparam int unsigned SW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               in_valid,
  input  logic               reg_we,
  input  logic [AW-1:0]      rt,
  input  logic [AW-1:0]      rd,
  input  logic [1:0]         dst_sel,
  input  logic [NSRC*DW-1:0] src_data,
  input  logic [SW-1:0]      src_sel,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
  output logic               fwd_hit_rt,
  output logic               fwd_hit_rd,
  output logic [CW-1:0]      commit_cnt
);

  logic          w_dst_ok;
  logic [AW-1:0] w_addr;
  logic          w_sel_ok;
  logic [DW-1:0] w_data;
  logic          w_qual_we;

  logic          r_valid;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;

  always_comb begin
    w_addr   = '0;
    w_dst_ok = 1'b1;
    unique case (dst_sel)
      2'b00:   w_addr = rt;
      2'b01:   w_addr = rd;
      2'b10:   w_addr = AW'(LINK);
      default: w_dst_ok = 1'b0;
    endcase
  end

  // Out-of-range indices (possible when NSRC is not a power of two) give zero data.
  always_comb begin
    w_data   = '0;
    w_sel_ok = (32'(src_sel) < NSRC);
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (32'(src_sel) == k) w_data = src_data[k*DW +: DW];
    end
  end

  assign w_qual_we = in_valid & reg_we & w_dst_ok & (w_addr != '0) & w_sel_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (clr) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (en) begin
      r_valid <= in_valid;
      r_we    <= w_qual_we;
      r_addr  <= w_addr;
      r_data  <= w_data;
      if (w_qual_we) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign wb_valid   = r_valid;
  assign wb_we      = r_we;
  assign wb_addr    = r_addr;
  assign wb_data    = r_data;
  assign commit_cnt = r_cnt;

  // The address-zero guard is redundant with the qualified enable but keeps $0 unforwardable.
  assign fwd_hit_rt = r_we & (r_addr != '0) & (r_addr == rt);
  assign fwd_hit_rd = r_we & (r_addr != '0) & (r_addr == rd);

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Scoreboard bench for wb_sel_pipe with NSRC=3 (exercises an out-of-range select) and CW=4
// (exercises counter wrap); expected values are hand-computed per vector.
module tb_wb_sel_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NSRC = 3;
  localparam int unsigned CW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en, clr, in_valid, reg_we;
  logic [AW-1:0]    rt, rd;
  logic [1:0]       dst_sel;
  logic [NSRC*DW-1:0] src_data;
  logic [1:0]       src_sel;
  logic             wb_valid, wb_we, fwd_hit_rt, fwd_hit_rd;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [CW-1:0]    commit_cnt;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_sel_pipe #(.DW(DW), .AW(AW), .NSRC(NSRC), .LINK(31), .CW(CW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .in_valid   (in_valid),
    .reg_we     (reg_we),
    .rt         (rt),
    .rd         (rd),
    .dst_sel    (dst_sel),
    .src_data   (src_data),
    .src_sel    (src_sel),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .fwd_hit_rt (fwd_hit_rt),
    .fwd_hit_rd (fwd_hit_rd),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares registered outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("wb_valid", 32'(wb_valid), 32'(m_e.v));
      chk("wb_we", 32'(wb_we), 32'(m_e.we));
      chk("wb_addr", 32'(wb_addr), 32'(m_e.addr));
      chk("wb_data", wb_data, m_e.data);
      chk("commit_cnt", 32'(commit_cnt), 32'(m_e.cnt));
      chk("fwd_hit_rt", 32'(fwd_hit_rt), 32'(m_e.we && m_e.addr == rt && m_e.addr != '0));
      chk("fwd_hit_rd", 32'(fwd_hit_rd), 32'(m_e.we && m_e.addr == rd && m_e.addr != '0));
    end
  end

  task automatic vec(input logic i_en, input logic i_clr, input logic i_v, input logic i_we,
                     input logic [AW-1:0] i_rt, input logic [AW-1:0] i_rd,
                     input logic [1:0] i_dst, input logic [1:0] i_sel,
                     input logic e_v, input logic e_we, input logic [AW-1:0] e_addr,
                     input logic [DW-1:0] e_data, input logic [CW-1:0] e_cnt);
    exp_t e;
    en = i_en; clr = i_clr; in_valid = i_v; reg_we = i_we;
    rt = i_rt; rd = i_rd; dst_sel = i_dst; src_sel = i_sel;
    e.v = e_v; e.we = e_we; e.addr = e_addr; e.data = e_data; e.cnt = e_cnt;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_we"}, 32'(wb_we), 32'd0);
    chk({tag, "_addr"}, 32'(wb_addr), 32'd0);
    chk({tag, "_data"}, wb_data, 32'd0);
    chk({tag, "_cnt"}, 32'(commit_cnt), 32'd0);
  endtask

  localparam logic [DW-1:0] S0 = 32'hA0A0_0000;
  localparam logic [DW-1:0] S1 = 32'h1234_5678;
  localparam logic [DW-1:0] S2 = 32'h0000_3008;

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; reg_we = 1'b0;
    rt = '0; rd = '0; dst_sel = 2'b00; src_sel = 2'b00;
    src_data = {S2, S1, S0};
    #3 chk_zero("rst");
    @(negedge clk); #1 reset = 1'b1;

    //  en clr v we  rt rd  dst    sel     v we addr data cnt
    vec(1, 0, 1, 1, 3, 8, 2'b01, 2'd1,    1, 1, 8,  S1, 1);  // basic select
    vec(1, 0, 1, 1, 3, 8, 2'b10, 2'd2,    1, 1, 31, S2, 2);  // link write
    vec(1, 0, 1, 1, 0, 8, 2'b00, 2'd1,    1, 0, 0,  S1, 2);  // rt=$0 suppressed
    vec(1, 0, 1, 1, 5, 8, 2'b11, 2'd0,    1, 0, 0,  S0, 2);  // no destination
    vec(1, 0, 1, 1, 5, 8, 2'b00, 2'd0,    1, 1, 5,  S0, 3);
    vec(0, 0, 1, 1, 7, 9, 2'b01, 2'd2,    1, 1, 5,  S0, 3);  // stall: hold
    vec(0, 0, 0, 0, 5, 5, 2'b10, 2'd1,    1, 1, 5,  S0, 3);
    vec(0, 0, 1, 1, 2, 5, 2'b00, 2'd2,    1, 1, 5,  S0, 3);
    vec(0, 1, 1, 1, 5, 5, 2'b00, 2'd1,    0, 0, 0,  0,  3);  // flush during stall
    vec(1, 0, 1, 1, 3, 4, 2'b01, 2'd3,    1, 0, 4,  0,  3);  // out-of-range select
    vec(1, 0, 0, 1, 3, 4, 2'b01, 2'd1,    0, 0, 4,  S1, 3);  // invalid slot
    vec(1, 0, 1, 0, 3, 4, 2'b01, 2'd1,    1, 0, 4,  S1, 3);  // non-writing instruction
    vec(1, 1, 1, 1, 3, 4, 2'b01, 2'd1,    0, 0, 0,  0,  3);  // flush beats enable

    // 13 more commits bring the total to 16, wrapping the 4-bit counter to 0.
    for (int i = 1; i <= 13; i++)
      vec(1, 0, 1, 1, 0, AW'(i), 2'b01, 2'd1, 1, 1, AW'(i), S1, CW'(3 + i));

    // Asynchronous reset between edges while a commit is being presented.
    en = 1'b1; in_valid = 1'b1; reg_we = 1'b1; dst_sel = 2'b01; rd = 5'd6; src_sel = 2'd2;
    @(negedge clk); #2 reset = 1'b0;
    #1 chk_zero("arst");
    vec(1, 0, 1, 1, 0, 6, 2'b01, 2'd2,    0, 0, 0,  0,  0);  // held in reset
    @(negedge clk); #1 reset = 1'b1;
    vec(1, 0, 1, 1, 0, 6, 2'b01, 2'd2,    1, 1, 6,  S2, 1);  // first edge after release
    vec(0, 0, 1, 1, 6, 6, 2'b00, 2'd1,    1, 1, 6,  S2, 1);

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_sel_pipe.md
WB_SEL_PIPE -- requirements
Module: wb_sel_pipe

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning), one per line:
- DW, 32, data width.
- AW, 5, register-address width.
- NSRC, 4, number of write-back sources (2..8).
- LINK, 31, link-register index.
- CW, 32, commit-counter width.
REQ-002 The module SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- en, in, 1, stage enable; 0 = stall/hold.
- clr, in, 1, synchronous flush (bubble insert).
- in_valid, in, 1, upstream instruction valid.
- reg_we, in, 1, instruction writes the register file.
- rt, in, AW, rt field.
- rd, in, AW, rd field.
- dst_sel, in, 2, destination select: 00 rt, 01 rd, 10 LINK, 11 no destination.
- src_data, in, NSRC*DW, flattened sources; source k at bits [k*DW +: DW].
- src_sel, in, clog2(NSRC), write-back source index.
- wb_valid, out, 1, registered stage valid.
- wb_we, out, 1, registered qualified write enable.
- wb_addr, out, AW, registered destination.
- wb_data, out, DW, registered write data.
- fwd_hit_rt, out, 1, combinational: wb_we and wb_addr==rt.
- fwd_hit_rd, out, 1, combinational: wb_we and wb_addr==rd.
- commit_cnt, out, CW, count of committed register writes.

Function
REQ-003 Destination decode SHALL be combinational: 00 -> rt; 01 -> rd; 10 -> LINK; 11 -> address 0 with write suppressed.
REQ-004 Data select SHALL be combinational: src_sel<NSRC -> source src_sel; src_sel>=NSRC -> all-zero data with write suppressed.
REQ-005 Qualified write enable SHALL be in_valid AND reg_we AND dst_sel!=11 AND decoded address!=0 AND src_sel<NSRC.
REQ-006 On a rising clk with clr=1, wb_valid, wb_we, wb_addr, wb_data SHALL all load 0, regardless of en.
REQ-007 On a rising clk with clr=0, en=1, wb_valid SHALL load in_valid, wb_we the qualified enable, wb_addr the decoded address, wb_data the selected data.
REQ-008 On a rising clk with clr=0, en=0, all registered outputs and commit_cnt SHALL hold.
REQ-009 Latency SHALL be exactly one cycle from input to wb_* outputs; no combinational input-to-wb_* path.
REQ-010 commit_cnt SHALL increment by 1 on each rising clk where clr=0, en=1 and the qualified enable is 1, and SHALL wrap from 2^CW-1 to 0.
REQ-011 fwd_hit_rt and fwd_hit_rd SHALL be 0 whenever wb_we=0 and SHALL never assert for address 0.
REQ-012 A wb_valid=1 entry with wb_we=0 SHALL be a legal non-writing instruction (e.g. store, branch).
REQ-013 An instruction that is flushed SHALL never be counted and SHALL never produce wb_we=1.

Reset
REQ-014 While reset=0, wb_valid, wb_we, wb_addr, wb_data and commit_cnt SHALL be 0 immediately, independent of clk.
REQ-015 Reset asserted mid-stall or mid-flush SHALL override both; the first rising clk after deassertion SHALL behave per REQ-006..REQ-008.

Verification
REQ-016 Basic select:
- Stimulus: in_valid=1, reg_we=1, dst_sel=01, rd=8, src_sel=1, source1=0x1234_5678.
- Response: after one edge, wb_we=1, wb_addr=8, wb_data=0x1234_5678, commit_cnt=1.
REQ-017 Link write:
- Stimulus: dst_sel=10, src_sel=2, source2=0x0000_3008.
- Response: wb_addr=31, wb_data=0x0000_3008, wb_we=1.
REQ-018 $0 and no-destination suppression:
- Stimulus: rt=0 with dst_sel=00; separately, dst_sel=11.
- Response: wb_we=0, commit_cnt unchanged, fwd_hit_* = 0.
REQ-019 Stall then flush:
- Stimulus: en=0 for 3 cycles with changing inputs; then clr=1 together with en=0.
- Response: outputs hold across the stall; after the flush edge, all wb_* = 0 and commit_cnt unchanged.
REQ-020 Counter wrap and async reset:
- Stimulus: CW=4, 16 committed writes; then reset=0 between clock edges.
- Response: commit_cnt reads 0 after the 16th write; all outputs reach 0 before the next edge.
REQ-021 Out-of-range select:
- Stimulus: NSRC=3, src_sel=3.
- Response: wb_data=0, wb_we=0, wb_valid=in_valid.
